uart_rcv: RTL



---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_rcv.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive/transmit pair.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam int UART_BAUD_DIV_DFLT = 2604;
    localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Down-counting bit timer: load sets the phase, tick fires when the count reaches 1
// and the counter then reloads a full bit period.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 2604,
    parameter int CW       = $clog2(BAUD_DIV + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tick
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (tick)
            cnt_d = CW'(BAUD_DIV);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing and overrun flags.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int CW = $clog2(BAUD_DIV + 1);

    // sync_q[1] is the synchronized line, sync_q[2] its one-cycle-old copy.
    logic [2:0] sync_q;
    logic       rx_s, rx_q, fall;

    assign rx_s = sync_q[1];
    assign rx_q = sync_q[2];
    assign fall = rx_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 3'b111;
        else     sync_q <= {sync_q[1:0], RX};
    end

    uart_rx_state_t               state_q, state_d;
    logic [2:0]                   bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]    rx_data_q, rx_data_d;
    logic                         rdy_q, rdy_d;
    logic                         frm_err_q, frm_err_d;
    logic                         ovr_err_q, ovr_err_d;
    logic                         unread_q, unread_d;
    logic                         baud_load, tick;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV), .CW(CW)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (baud_load),
        .load_val (CW'(BAUD_DIV / 2)),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        frm_err_d = frm_err_q;
        ovr_err_d = ovr_err_q;
        unread_d  = unread_q;
        baud_load = 1'b0;

        // unread survives the start-bit clear of rdy, so a byte the consumer
        // never acknowledged is still caught as an overrun by the next frame.
        if (clr_rdy) begin
            rdy_d     = 1'b0;
            ovr_err_d = 1'b0;
            unread_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d   = START;
                    baud_load = 1'b1;
                    rdy_d     = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        frm_err_d = 1'b0;
                        unread_d  = 1'b1;
                        if (unread_q && !clr_rdy) ovr_err_d = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            unread_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
            unread_q  <= unread_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule
